// File: rtl/zl_sync_invert_derandomizer_pkg.sv
// Shared constants and state encoding for the DVB-S sync-invert derandomizer.
// The PRBS literal lists register bits r1..r15 from left to right (r1 = bit 14).
package zl_sync_invert_derandomizer_pkg;

  localparam logic [7:0]  SYNC_BYTE       = 8'h47;
  localparam logic [7:0]  SYNC_BYTE_INV   = 8'hB8;
  localparam logic [14:0] PRBS_INIT       = 15'b100101010000000;

  localparam int PKT_LEN_DEF     = 188;
  localparam int GROUP_LEN_DEF   = 8;
  localparam int MISS_THRESH_DEF = 3;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_e;

  // The first packet of every PRBS group carries the inverted sync byte.
  function automatic logic [7:0] expected_sync(input logic first_pkt);
    return first_pkt ? SYNC_BYTE_INV : SYNC_BYTE;
  endfunction

endpackage

// File: rtl/zl_dvb_prbs.sv
// Combinational 8-step unroll of the 1+x^14+x^15 generator, MSB first.
// Bit 14 of the state is r1 and bit 0 is r15; no registers live here.
module zl_dvb_prbs (
  input  logic [14:0] state_i,
  output logic [14:0] state_o,
  output logic [7:0]  byte_o
);

  logic [14:0] s;
  logic        fb;

  always_comb begin
    s      = state_i;
    fb     = 1'b0;
    byte_o = '0;
    for (int i = 0; i < 8; i++) begin
      fb            = s[1] ^ s[0];
      byte_o[7 - i] = fb;
      s             = {fb, s[14:1]};
    end
    state_o = s;
  end

endmodule

// File: rtl/zl_sync_invert_derandomizer.sv
// Receive-side DVB-S derandomizer: acquires group alignment from 0xB8/0x47 sync
// bytes, strips the energy-dispersal PRBS and restores every sync byte to 0x47.
module zl_sync_invert_derandomizer
  import zl_sync_invert_derandomizer_pkg::*;
#(
  parameter int PKT_LEN     = PKT_LEN_DEF,
  parameter int GROUP_LEN   = GROUP_LEN_DEF,
  parameter int MISS_THRESH = MISS_THRESH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_in_req,
  output logic       data_in_ack,
  output logic [7:0] data_out,
  output logic       data_out_req,
  input  logic       data_out_ack,
  output logic       data_out_sop,
  output logic       lock,
  output logic       sync_err
);

  localparam int BW = $clog2(PKT_LEN);
  localparam int PW = $clog2(GROUP_LEN);
  localparam int MW = $clog2(MISS_THRESH + 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [PW-1:0]   pkt_cnt_q, pkt_cnt_d, pkt_cnt_inc;
  logic [MW-1:0]   miss_cnt_q, miss_cnt_d;
  logic [14:0]     prbs_q, prbs_d, prbs_next, prbs_adv;
  logic [7:0]      prbs_byte;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_req_q, out_req_d;
  logic            out_sop_q, out_sop_d;
  logic            sync_err_q, sync_err_d;

  logic            accept, out_free, sync_pos, first_pkt, sync_ok;
  logic            byte_last, pkt_last;
  logic            load, load_sop;
  logic [7:0]      load_data;

  zl_dvb_prbs u_prbs (
    .state_i (prbs_q),
    .state_o (prbs_next),
    .byte_o  (prbs_byte)
  );

  assign out_free    = !out_req_q || data_out_ack;
  assign data_in_ack = (state_q == ST_HUNT) || out_free;
  assign accept      = data_in_req && data_in_ack;

  assign sync_pos  = (byte_cnt_q == '0);
  assign first_pkt = (pkt_cnt_q == '0);
  assign sync_ok   = (data_in == expected_sync(first_pkt));
  assign byte_last = (byte_cnt_q == BW'(PKT_LEN - 1));
  assign pkt_last  = (pkt_cnt_q == PW'(GROUP_LEN - 1));

  assign byte_cnt_inc = byte_last ? '0 : byte_cnt_q + BW'(1);
  assign pkt_cnt_inc  = byte_last ? (pkt_last ? '0 : pkt_cnt_q + PW'(1)) : pkt_cnt_q;
  // The group's first byte reloads the generator so the next byte sees PRBS_INIT.
  assign prbs_adv     = (sync_pos && first_pkt) ? PRBS_INIT : prbs_next;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    miss_cnt_d = miss_cnt_q;
    prbs_d     = prbs_q;
    sync_err_d = 1'b0;
    load       = 1'b0;
    load_data  = out_data_q;
    load_sop   = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (accept && data_in == SYNC_BYTE_INV) begin
          state_d    = ST_VERIFY;
          byte_cnt_d = BW'(1);
          pkt_cnt_d  = '0;
          prbs_d     = PRBS_INIT;
        end
      end

      ST_VERIFY: begin
        if (accept) begin
          if (sync_pos && !sync_ok) begin
            byte_cnt_d = '0;
            pkt_cnt_d  = '0;
            prbs_d     = PRBS_INIT;
            state_d    = ST_HUNT;
            // A stray 0xB8 at the check point may itself be a new group start.
            if (data_in == SYNC_BYTE_INV) begin
              state_d    = ST_VERIFY;
              byte_cnt_d = BW'(1);
            end
          end else begin
            byte_cnt_d = byte_cnt_inc;
            pkt_cnt_d  = pkt_cnt_inc;
            prbs_d     = prbs_adv;
            if (sync_pos && first_pkt) begin
              state_d    = ST_LOCK;
              miss_cnt_d = '0;
              load       = 1'b1;
              load_data  = SYNC_BYTE;
              load_sop   = 1'b1;
            end
          end
        end
      end

      ST_LOCK: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_inc;
          pkt_cnt_d  = pkt_cnt_inc;
          prbs_d     = prbs_adv;
          if (sync_pos) begin
            sync_err_d = !sync_ok;
            if (sync_ok) begin
              miss_cnt_d = '0;
              load       = 1'b1;
              load_data  = SYNC_BYTE;
              load_sop   = 1'b1;
            end else if (miss_cnt_q == MW'(MISS_THRESH - 1)) begin
              state_d    = ST_HUNT;
              byte_cnt_d = '0;
              pkt_cnt_d  = '0;
              miss_cnt_d = '0;
              prbs_d     = PRBS_INIT;
            end else begin
              miss_cnt_d = miss_cnt_q + MW'(1);
              load       = 1'b1;
              load_data  = SYNC_BYTE;
              load_sop   = 1'b1;
            end
          end else begin
            load      = 1'b1;
            load_data = data_in ^ prbs_byte;
          end
        end
      end

      default: state_d = ST_HUNT;
    endcase

    // Loads only happen when the register is free, so a stalled byte is never overwritten.
    out_req_d  = load || (out_req_q && !data_out_ack);
    out_data_d = load ? load_data : out_data_q;
    out_sop_d  = load ? load_sop : out_sop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      byte_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      miss_cnt_q <= '0;
      prbs_q     <= PRBS_INIT;
      out_data_q <= '0;
      out_req_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      prbs_q     <= prbs_d;
      out_data_q <= out_data_d;
      out_req_q  <= out_req_d;
      out_sop_q  <= out_sop_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign data_out     = out_data_q;
  assign data_out_req = out_req_q;
  assign data_out_sop = out_sop_q;
  assign sync_err     = sync_err_q;
  assign lock         = (state_q == ST_LOCK);

endmodule

// File: tb/tb_zl_sync_invert_derandomizer.sv
// Directed bench for zl_sync_invert_derandomizer: a reference randomizer builds
// encoded groups, a negedge monitor scores every output transfer in order.
module tb_zl_sync_invert_derandomizer;

  localparam int PKT = 188;
  localparam int GRP = 8;
  localparam int G   = PKT * GRP;
  localparam int BIG = 1 << 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_req = 1'b0;
  logic       data_in_ack;
  logic [7:0] data_out;
  logic       data_out_req;
  logic       data_out_ack = 1'b1;
  logic       data_out_sop;
  logic       lock;
  logic       sync_err;

  int total = 0;
  int bad = 0;
  int extra_cnt = 0;
  int out_cnt = 0;
  int sync_err_cnt = 0;
  int ack_mode = 0;

  logic [8:0] exp_q[$];
  logic [7:0] enc[$];
  logic [8:0] expd[$];
  logic       stall_prev = 1'b0;
  logic [8:0] held = '0;
  logic [8:0] e;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic       sop;
  } vec_t;
  vec_t tbl[3];

  always #5 clk = ~clk;

  zl_sync_invert_derandomizer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_in_req  (data_in_req),
    .data_in_ack  (data_in_ack),
    .data_out     (data_out),
    .data_out_req (data_out_req),
    .data_out_ack (data_out_ack),
    .data_out_sop (data_out_sop),
    .lock         (lock),
    .sync_err     (sync_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Downstream acceptance: 0 = always, 1 = random, 2 = never.
  always @(posedge clk) begin
    #1;
    if (ack_mode == 1) data_out_ack = 1'($urandom_range(0, 1));
    else               data_out_ack = (ack_mode == 0);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (sync_err) sync_err_cnt++;
      if (stall_prev) begin
        checkOutput("hold_req", 32'(data_out_req), 32'd1);
        checkOutput("hold_data", 32'({data_out_sop, data_out}), 32'(held));
      end
      if (data_out_req && data_out_ack) begin
        out_cnt++;
        if (exp_q.size() == 0) extra_cnt++;
        else begin
          e = exp_q.pop_front();
          checkOutput("out_byte", 32'({data_out_sop, data_out}), 32'(e));
        end
      end
      stall_prev = data_out_req && !data_out_ack;
      held       = {data_out_sop, data_out};
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input bit throttle);
    int guard;
    if (throttle) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    data_in     = b;
    data_in_req = 1'b1;
    guard       = 0;
    forever begin
      @(negedge clk);
      if (data_in_ack) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 500) begin
        total++;
        bad++;
        $display("[TB] FAIL in_timeout: got stalled %0d cycles want accept", guard);
        break;
      end
    end
    data_in_req = 1'b0;
  endtask

  // Reference DVB-S randomizer, register held as r[15:1] with r[k] = stage k.
  task automatic gen_groups(input int n, input bit zero);
    logic [15:1] r;
    logic [7:0]  pb;
    logic [7:0]  pay;
    logic        fb;
    r  = 15'b000000010101001;
    pb = '0;
    for (int g = 0; g < n; g++)
      for (int p = 0; p < GRP; p++)
        for (int b = 0; b < PKT; b++) begin
          if (p == 0 && b == 0) r = 15'b000000010101001;
          else begin
            pb = '0;
            for (int k = 0; k < 8; k++) begin
              fb = r[14] ^ r[15];
              r  = {r[14:1], fb};
              pb = {pb[6:0], fb};
            end
          end
          pay = zero ? 8'h00 : 8'($urandom_range(0, 255));
          if (b == 0) begin
            enc.push_back(p == 0 ? 8'hB8 : 8'h47);
            expd.push_back({1'b1, 8'h47});
          end else begin
            enc.push_back(pay ^ pb);
            expd.push_back({1'b0, pay});
          end
        end
  endtask

  task automatic send_stream(input int lo, input int hi, input int elo, input int ehi, input bit throttle);
    for (int i = lo; i < hi; i++) begin
      if (i >= elo && i < ehi) exp_q.push_back(expd[i]);
      applyStimulus(enc[i], throttle);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || data_out_req) && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic endCheck(input string tag, input int outs);
    checkOutput({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_extra"}, 32'(extra_cnt), 32'd0);
    checkOutput({tag, "_count"}, 32'(out_cnt), 32'(outs));
  endtask

  task automatic do_reset();
    data_in_req = 1'b0;
    rst_n       = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    exp_q.delete();
    enc.delete();
    expd.delete();
    extra_cnt    = 0;
    out_cnt      = 0;
    sync_err_cnt = 0;
    rst_n        = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] v;
    tbl[0] = '{din: 8'hB8, dout: 8'h47, sop: 1'b1};
    tbl[1] = '{din: 8'h03, dout: 8'h00, sop: 1'b0};
    tbl[2] = '{din: 8'hF6, dout: 8'h00, sop: 1'b0};

    // Reset values
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("rst_req", 32'(data_out_req), 32'd0);
    checkOutput("rst_data", 32'(data_out), 32'd0);
    checkOutput("rst_sop", 32'(data_out_sop), 32'd0);
    checkOutput("rst_lock", 32'(lock), 32'd0);
    checkOutput("rst_serr", 32'(sync_err), 32'd0);

    $display("[TB] test 1: three encoded groups");
    do_reset();
    gen_groups(3, 1'b0);
    send_stream(0, G / 2, BIG, BIG, 1'b0);
    checkOutput("t1_lock_early", 32'(lock), 32'd0);
    send_stream(G / 2, G, BIG, BIG, 1'b0);
    checkOutput("t1_lock_pre", 32'(lock), 32'd0);
    send_stream(G, G + 1, G, 3 * G, 1'b0);
    checkOutput("t1_lock_rise", 32'(lock), 32'd1);
    send_stream(G + 1, 3 * G, G, 3 * G, 1'b0);
    drain();
    endCheck("t1", 2 * G);
    checkOutput("t1_lock_end", 32'(lock), 32'd1);

    $display("[TB] test 2: zero payload, table vectors at group start");
    do_reset();
    gen_groups(2, 1'b1);
    send_stream(0, G, BIG, BIG, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({tbl[i].sop, tbl[i].dout});
      applyStimulus(tbl[i].din, 1'b0);
    end
    send_stream(G + 3, 2 * G, G + 3, 2 * G, 1'b0);
    drain();
    endCheck("t2", G);

    $display("[TB] test 3: random bytes with a spurious 0xB8");
    do_reset();
    for (int i = 0; i < 500; i++) begin
      do v = 8'($urandom_range(0, 255)); while (v == 8'h47 || v == 8'hB8);
      if (i == 100) v = 8'hB8;
      applyStimulus(v, 1'b0);
    end
    checkOutput("t3_lock_rand", 32'(lock), 32'd0);
    checkOutput("t3_extra_rand", 32'(extra_cnt), 32'd0);
    gen_groups(3, 1'b0);
    send_stream(0, 3 * G, G, 3 * G, 1'b0);
    drain();
    endCheck("t3", 2 * G);
    checkOutput("t3_lock_end", 32'(lock), 32'd1);

    $display("[TB] test 4: corrupted sync bytes in lock");
    do_reset();
    gen_groups(3, 1'b0);
    enc[2 * G + 1 * PKT] = 8'h00;
    enc[2 * G + 2 * PKT] = 8'h12;
    enc[2 * G + 4 * PKT] = 8'h00;
    enc[2 * G + 5 * PKT] = 8'hFF;
    enc[2 * G + 6 * PKT] = 8'h46;
    send_stream(0, 2 * G + 3 * PKT + 1, G, 2 * G + 6 * PKT, 1'b0);
    checkOutput("t4_lock_two", 32'(lock), 32'd1);
    checkOutput("t4_err_two", 32'(sync_err_cnt), 32'd2);
    send_stream(2 * G + 3 * PKT + 1, 2 * G + 6 * PKT, G, 2 * G + 6 * PKT, 1'b0);
    checkOutput("t4_lock_pre3", 32'(lock), 32'd1);
    send_stream(2 * G + 6 * PKT, 2 * G + 6 * PKT + 1, G, 2 * G + 6 * PKT, 1'b0);
    checkOutput("t4_lock_drop", 32'(lock), 32'd0);
    send_stream(2 * G + 6 * PKT + 1, 2 * G + 6 * PKT + 11, BIG, BIG, 1'b0);
    drain();
    checkOutput("t4_err_total", 32'(sync_err_cnt), 32'd5);
    checkOutput("t4_lock_end", 32'(lock), 32'd0);
    endCheck("t4", G + 6 * PKT);

    $display("[TB] test 5: throttled input and output");
    do_reset();
    ack_mode = 1;
    gen_groups(4, 1'b0);
    send_stream(0, 4 * G, G, 4 * G, 1'b1);
    drain();
    ack_mode = 0;
    endCheck("t5", 3 * G);

    $display("[TB] test 6: reset with a pending output byte");
    do_reset();
    gen_groups(3, 1'b0);
    send_stream(0, 2 * G + 50, G, 2 * G + 50, 1'b0);
    drain();
    endCheck("t6_pre", G + 50);
    ack_mode = 2;
    repeat (2) begin @(posedge clk); #1; end
    exp_q.push_back(expd[2 * G + 50]);
    applyStimulus(enc[2 * G + 50], 1'b0);
    checkOutput("t6_req_pending", 32'(data_out_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_req_async", 32'(data_out_req), 32'd0);
    checkOutput("t6_lock_async", 32'(lock), 32'd0);
    ack_mode = 0;
    do_reset();
    gen_groups(2, 1'b0);
    send_stream(0, 2 * G, G, 2 * G, 1'b0);
    drain();
    endCheck("t6", G);
    checkOutput("t6_lock_end", 32'(lock), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
